// File: rtl/bcd_seg7_pkg.sv
// Shared types and segment constants for the sequential binary-to-seven-segment converter.
// Segment fields are active low, bit order {g,f,e,d,c,b,a} from MSB to LSB.
package bcd_seg7_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Index n holds the pattern for decimal digit n.
    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Double-dabble correction applied to every nibble before each shift.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/bcd_seg7_decoder.sv
// Combinational decoder from one BCD digit to an active-low seven-segment field.
// Codes 10..15 cannot come out of the converter but still show a dash.
module bcd_seg7_decoder
    import bcd_seg7_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // NOTE: seg gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_BLANK;
        end else if (digit <= 4'd9) begin
            seg = SEG_DIGIT[digit];
        end
    end

endmodule

// File: rtl/bcd_seg7_converter.sv
// Sequential binary-to-BCD converter (shift-add-3, one input bit per clock) driving
// DIGITS active-low seven-segment fields with leading-zero blanking and overflow dashes.
module bcd_seg7_converter
    import bcd_seg7_pkg::*;
#(
    parameter int IN_WIDTH      = 8,
    parameter int DIGITS        = 3,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   value,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   display
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SEG_W = 7 * DIGITS;
    localparam int CNT_W = $clog2(IN_WIDTH + 1);

    state_t              state;
    logic [IN_WIDTH-1:0] shift_reg;
    logic [BCD_W-1:0]    bcd_acc;
    logic                ovf_acc;
    logic [CNT_W-1:0]    bit_cnt;

    logic [BCD_W-1:0]    bcd_adj;
    logic [BCD_W-1:0]    bcd_next;
    logic [IN_WIDTH-1:0] shift_next;
    logic                ovf_next;
    logic [DIGITS-1:0]   blank_vec;
    logic                zero_above;
    logic [SEG_W-1:0]    seg_dec;
    logic [SEG_W-1:0]    display_next;

    // One shift-add-3 step; the MSB of the corrected top nibble is the bit lost off the top.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            bcd_adj[4*i +: 4] = add3(bcd_acc[4*i +: 4]);
        end
        {bcd_next, shift_next} = {bcd_adj[BCD_W-2:0], shift_reg, 1'b0};
        ovf_next = ovf_acc | bcd_adj[BCD_W-1];
    end

    // A digit above the units is blank when it and every digit above it are zero.
    always_comb begin
        blank_vec  = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_above   = zero_above && (bcd_next[4*i +: 4] == 4'd0);
            blank_vec[i] = BLANK_LEADING && zero_above;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        bcd_seg7_decoder u_dec (
            .digit (bcd_next[4*g +: 4]),
            .blank (blank_vec[g]),
            .seg   (seg_dec[7*g +: 7])
        );
    end

    assign display_next = ovf_next ? {DIGITS{SEG_DASH}} : seg_dec;

    // NOTE: state and datapath registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, matching the hardware.
    // NOTE: the working registers are reset too; they are small and it keeps simulation X-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            bcd       <= '0;
            display   <= '1;
            shift_reg <= '0;
            bcd_acc   <= '0;
            ovf_acc   <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= value;
                        bcd_acc   <= '0;
                        ovf_acc   <= 1'b0;
                        bit_cnt   <= CNT_W'(IN_WIDTH);
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_next;
                    bcd_acc   <= bcd_next;
                    ovf_acc   <= ovf_next;
                    bit_cnt   <= bit_cnt - CNT_W'(1);
                    // Outputs change only here, so they never expose a partial result.
                    if (bit_cnt == CNT_W'(1)) begin
                        bcd      <= bcd_next;
                        display  <= display_next;
                        overflow <= ovf_next;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
